// File: rtl/bus_term_fifo.sv
// ============================================================================
// Module   : bus_term_fifo
// Brief    : Per-terminal TX/RX FIFO pair between one device and one bus port.
//            Optional RX destination filtering: BUS_TERM_ADDR_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_term_fifo #(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'd0,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [pckg_sz-1:0]       wr_data,
    output logic                     tx_full,
    output logic [$clog2(depth):0]   tx_cnt,
    output logic                     pndng,
    output logic [pckg_sz-1:0]       D_pop,
    input  logic                     pop,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       D_push,
    input  logic                     rd_en,
    output logic [pckg_sz-1:0]       rd_data,
    output logic                     rx_empty,
    output logic [$clog2(depth):0]   rx_cnt,
    output logic [1:0]               err_ovf,
    input  logic                     clr_err
);

    localparam int              AW     = $clog2(depth);
    localparam int              CW     = AW + 1;
    localparam logic [CW-1:0]   c_FULL = CW'(depth);

    logic [pckg_sz-1:0] r_tx_mem [depth];
    logic [AW-1:0]      r_tx_wr_ptr;
    logic [AW-1:0]      r_tx_rd_ptr;
    logic [CW-1:0]      r_tx_cnt;

    logic [pckg_sz-1:0] r_rx_mem [depth];
    logic [AW-1:0]      r_rx_wr_ptr;
    logic [AW-1:0]      r_rx_rd_ptr;
    logic [CW-1:0]      r_rx_cnt;

    logic [1:0]         r_err_ovf;

    logic w_tx_full, w_tx_nemp, w_tx_rd, w_tx_wr, w_tx_drop;
    logic w_rx_full, w_rx_nemp, w_rx_rd, w_rx_wr, w_rx_drop, w_rx_match;

    // A write into a full FIFO is only legal when the same edge frees a slot.
    assign w_tx_full = (r_tx_cnt == c_FULL);
    assign w_tx_nemp = (r_tx_cnt != '0);
    assign w_tx_rd   = pop && w_tx_nemp;
    assign w_tx_wr   = wr_en && (!w_tx_full || w_tx_rd);
    assign w_tx_drop = wr_en && w_tx_full && !w_tx_rd;

`ifdef BUS_TERM_ADDR_FILTER_EN
    assign w_rx_match = (D_push[pckg_sz-1 -: 8] == id) ||
                        (D_push[pckg_sz-1 -: 8] == broadcast);
`else
    assign w_rx_match = 1'b1;
`endif

    assign w_rx_full = (r_rx_cnt == c_FULL);
    assign w_rx_nemp = (r_rx_cnt != '0);
    assign w_rx_rd   = rd_en && w_rx_nemp;
    assign w_rx_wr   = push && w_rx_match && (!w_rx_full || w_rx_rd);
    assign w_rx_drop = push && w_rx_match && w_rx_full && !w_rx_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) r_tx_mem[i] <= '0;
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_cnt    <= '0;
        end else begin
            if (w_tx_wr) begin
                r_tx_mem[r_tx_wr_ptr] <= wr_data;
                r_tx_wr_ptr           <= r_tx_wr_ptr + 1'b1;
            end
            if (w_tx_rd) r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
            case ({w_tx_wr, w_tx_rd})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) r_rx_mem[i] <= '0;
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_cnt    <= '0;
        end else begin
            if (w_rx_wr) begin
                r_rx_mem[r_rx_wr_ptr] <= D_push;
                r_rx_wr_ptr           <= r_rx_wr_ptr + 1'b1;
            end
            if (w_rx_rd) r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
            case ({w_rx_wr, w_rx_rd})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // Set-dominant: a drop on the clearing edge keeps its bit high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_err_ovf <= 2'b00;
        else        r_err_ovf <= (clr_err ? 2'b00 : r_err_ovf) | {w_rx_drop, w_tx_drop};
    end

    assign tx_full  = w_tx_full;
    assign tx_cnt   = r_tx_cnt;
    assign pndng    = w_tx_nemp;
    assign D_pop    = w_tx_nemp ? r_tx_mem[r_tx_rd_ptr] : '0;
    assign rd_data  = w_rx_nemp ? r_rx_mem[r_rx_rd_ptr] : '0;
    assign rx_empty = !w_rx_nemp;
    assign rx_cnt   = r_rx_cnt;
    assign err_ovf  = r_err_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bus_term_fifo.sv
// ============================================================================
// Module   : tb_bus_term_fifo
// Brief    : Randomised + directed bench for bus_term_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_term_fifo;

    localparam int         PW    = 16;
    localparam int         DEPTH = 8;
    localparam logic [7:0] TID   = 8'h01;
    localparam logic [7:0] BC    = 8'hFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en, pop, push, rd_en, clr_err;
    logic [PW-1:0] wr_data, D_push;
    logic          tx_full, pndng, rx_empty;
    logic [3:0]    tx_cnt, rx_cnt;
    logic [PW-1:0] D_pop, rd_data;
    logic [1:0]    err_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    logic [PW-1:0] txq[$];
    logic [PW-1:0] rxq[$];
    logic [1:0]    m_err;

    bus_term_fifo #(
        .pckg_sz   (PW),
        .depth     (DEPTH),
        .id        (TID),
        .broadcast (BC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx_full  (tx_full),
        .tx_cnt   (tx_cnt),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rx_empty (rx_empty),
        .rx_cnt   (rx_cnt),
        .err_ovf  (err_ovf),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_match(input logic [PW-1:0] d);
`ifdef BUS_TERM_ADDR_FILTER_EN
        return (d[PW-1 -: 8] == TID) || (d[PW-1 -: 8] == BC);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_all();
        chk("tx_cnt",   32'(tx_cnt),   32'(txq.size()));
        chk("tx_full",  32'(tx_full),  32'(txq.size() == DEPTH));
        chk("pndng",    32'(pndng),    32'(txq.size() != 0));
        chk("D_pop",    32'(D_pop),    32'((txq.size() != 0) ? txq[0] : 16'h0));
        chk("rx_cnt",   32'(rx_cnt),   32'(rxq.size()));
        chk("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
        chk("rd_data",  32'(rd_data),  32'((rxq.size() != 0) ? rxq[0] : 16'h0));
        chk("err_ovf",  32'(err_ovf),  32'(m_err));
    endtask

    // One clock of stimulus; the model applies the same request set at the edge.
    task automatic cycle(input logic w, input logic [PW-1:0] wd, input logic p,
                         input logic ps, input logic [PW-1:0] dp, input logic r,
                         input logic c);
        bit tpop, twr, tdrop, rrd, rm, rwr, rdrop;
        wr_en = w; wr_data = wd; pop = p; push = ps; D_push = dp; rd_en = r; clr_err = c;
        @(posedge clk);
        tpop  = p && (txq.size() > 0);
        twr   = w && ((txq.size() < DEPTH) || tpop);
        tdrop = w && !twr;
        rrd   = r && (rxq.size() > 0);
        rm    = ps && m_match(dp);
        rwr   = rm && ((rxq.size() < DEPTH) || rrd);
        rdrop = rm && !rwr;
        if (tpop) void'(txq.pop_front());
        if (twr)  txq.push_back(wd);
        if (rrd)  void'(rxq.pop_front());
        if (rwr)  rxq.push_back(dp);
        m_err = (c ? 2'b00 : m_err) | {rdrop, tdrop};
        #1;
        wr_en = 0; pop = 0; push = 0; rd_en = 0; clr_err = 0;
        check_all();
    endtask

    task automatic idle();
        cycle(0, '0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        int exp_rx;
        logic [PW-1:0] d;
        reset = 0; wr_en = 0; pop = 0; push = 0; rd_en = 0; clr_err = 0;
        wr_data = '0; D_push = '0; m_err = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_rx_empty", 32'(rx_empty), 32'd1);
        reset = 1;

        // First write / pop
        cycle(1, 16'h0203, 0, 0, '0, 0, 0);
        chk("first_pndng", 32'(pndng), 32'd1);
        chk("first_D_pop", 32'(D_pop), 32'h0203);
        chk("first_cnt",   32'(tx_cnt), 32'd1);
        cycle(0, '0, 1, 0, '0, 0, 0);
        chk("pop_pndng", 32'(pndng), 32'd0);

        // Fill TX, overflow, clear
        for (int i = 0; i < DEPTH; i++) cycle(1, 16'h1000 + 16'(i), 0, 0, '0, 0, 0);
        cycle(1, 16'hDEAD, 0, 0, '0, 0, 0);
        chk("ovf_full", 32'(tx_full), 32'd1);
        chk("ovf_err",  32'(err_ovf), 32'h1);
        cycle(0, '0, 0, 0, '0, 0, 1);
        chk("clr_err", 32'(err_ovf), 32'h0);

        // Full with simultaneous write and pop, then wrap the pointers
        cycle(1, 16'h2000, 1, 0, '0, 0, 0);
        chk("full_wrpop_cnt", 32'(tx_cnt), 32'd8);
        for (int i = 1; i < 16; i++) cycle(1, 16'h2000 + 16'(i), 1, 0, '0, 0, 0);
        cycle(1, 16'hBEEF, 0, 0, '0, 0, 1);
        chk("set_dominant", 32'(err_ovf), 32'h1);
        for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1, 0, '0, 0, 1);
        cycle(1, 16'h3333, 1, 0, '0, 0, 0);
        chk("empty_wrpop_cnt", 32'(tx_cnt), 32'd1);
        cycle(0, '0, 1, 0, '0, 0, 0);

        // RX destination filter
        cycle(0, '0, 0, 1, 16'hFF55, 0, 0);
        cycle(0, '0, 0, 1, 16'h0177, 0, 0);
        cycle(0, '0, 0, 1, 16'h0299, 0, 0);
`ifdef BUS_TERM_ADDR_FILTER_EN
        exp_rx = 2;
`else
        exp_rx = 3;
`endif
        chk("filter_cnt", 32'(rx_cnt), 32'(exp_rx));
        chk("rx_head", 32'(rd_data), 32'hFF55);

        // Fill RX, overflow, push+read while full
        for (int i = 0; i < 16 && rxq.size() < DEPTH; i++)
            cycle(0, '0, 0, 1, 16'h0140 + 16'(i), 0, 0);
        cycle(0, '0, 0, 1, 16'h01AA, 0, 0);
        chk("rx_ovf_err", 32'(err_ovf), 32'h2);
        cycle(0, '0, 0, 1, 16'h01BB, 1, 1);
        chk("rx_full_rdpush_cnt", 32'(rx_cnt), 32'd8);
        chk("rx_adv", 32'(rd_data), 32'h0177);
        for (int i = 0; i < DEPTH; i++) cycle(0, '0, 0, 0, '0, 1, 0);
        cycle(0, '0, 0, 1, 16'h01CC, 1, 0);
        chk("rx_empty_rdpush", 32'(rx_cnt), 32'd1);
        cycle(0, '0, 0, 0, '0, 1, 0);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) cycle(1, 16'h4000 + 16'(i), 0, 0, '0, 0, 0);
        cycle(0, '0, 0, 1, 16'h01DD, 0, 0);
        #2 reset = 0;
        #1;
        txq.delete(); rxq.delete(); m_err = 2'b00;
        chk("midrst_pndng", 32'(pndng), 32'd0);
        chk("midrst_cnt",   32'(tx_cnt), 32'd0);
        chk("midrst_D_pop", 32'(D_pop), 32'd0);
        check_all();
        @(posedge clk);
        #1 reset = 1;
        cycle(0, '0, 1, 0, '0, 1, 0);
        chk("post_rst_pop", 32'(tx_cnt), 32'd0);

        // Randomised traffic in producer-heavy and consumer-heavy phases
        for (int ph = 0; ph < 6; ph++) begin
            int wp, cp;
            wp = (ph % 2 == 0) ? 80 : 30;
            cp = (ph % 2 == 0) ? 30 : 80;
            for (int n = 0; n < 500; n++) begin
                case ($urandom_range(0, 3))
                    0:       d = {TID, 8'($urandom)};
                    1:       d = {BC, 8'($urandom)};
                    2:       d = {8'h02, 8'($urandom)};
                    default: d = 16'($urandom);
                endcase
                cycle($urandom_range(0, 99) < wp, 16'($urandom),
                      $urandom_range(0, 99) < cp,
                      $urandom_range(0, 99) < wp, d,
                      $urandom_range(0, 99) < cp,
                      $urandom_range(0, 99) < 5);
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
